// File: rtl/cnn_pkg.sv
// Shared types, kernels and activation/saturation for the two-lane 3x3 conv stage.
// CNN_RELU_EN (set by the build) selects ReLU + unsigned saturation; otherwise signed saturation.

package cnn_pkg;

  localparam int unsigned DW     = 8;
  localparam int unsigned SUM_W  = DW + 6;
  localparam int unsigned SHIFT0 = 4;
  localparam int unsigned SHIFT1 = 0;

  typedef logic [DW-1:0]           pix_t;
  typedef logic signed [SUM_W-1:0] sum_t;
  typedef logic signed [7:0]       kern_t [3][3];

  // Lane 0: Gaussian (sum 16); lane 1: Laplacian
  localparam kern_t K0 = '{'{8'sd1, 8'sd2, 8'sd1},
                           '{8'sd2, 8'sd4, 8'sd2},
                           '{8'sd1, 8'sd2, 8'sd1}};
  localparam kern_t K1 = '{'{ 8'sd0, -8'sd1,  8'sd0},
                           '{-8'sd1,  8'sd4, -8'sd1},
                           '{ 8'sd0, -8'sd1,  8'sd0}};

  localparam sum_t UMAX = sum_t'((1 << DW) - 1);
  localparam sum_t SMAX = sum_t'((1 << (DW - 1)) - 1);
  localparam sum_t SMIN = -SMAX - sum_t'(1);

  function automatic pix_t act_sat(sum_t v);
`ifdef CNN_RELU_EN
    if (v < 0)         return '0;
    else if (v > UMAX) return '1;
    else               return v[DW-1:0];
`else
    if (v > SMAX)      return {1'b0, {(DW-1){1'b1}}};
    else if (v < SMIN) return {1'b1, {(DW-1){1'b0}}};
    else               return v[DW-1:0];
`endif
  endfunction

endpackage

// File: rtl/cnn_if.sv
// Pixel-stream bundle for the two-lane conv stage: source drives x0/x1, stage drives y0/y1.
interface cnn_if #(parameter int unsigned DW = 8);
  logic [DW-1:0] x0;
  logic [DW-1:0] x1;
  logic [DW-1:0] y0;
  logic [DW-1:0] y1;

  modport master (output x0, output x1, input  y0, input  y1);
  modport slave  (input  x0, input  x1, output y0, output y1);
endinterface

// File: rtl/cnn_conv3x3_lane.sv
// One conv lane: column-addressed line buffers, 3x3 window, MAC register, act/sat output.
module cnn_conv3x3_lane
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W = 9,
  parameter kern_t       K     = K0,
  parameter int unsigned SHIFT = 4,
  localparam int unsigned CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  pix_t          x,
  input  logic [CW-1:0] col,
  input  logic          vld,
  output pix_t          y
);

  pix_t lb1_q [IMG_W];
  pix_t lb1_d [IMG_W];
  pix_t lb2_q [IMG_W];
  pix_t lb2_d [IMG_W];
  pix_t win_q [3][3];
  pix_t win_d [3][3];
  sum_t sum_q, sum_d;
  pix_t y_q, y_d;
  sum_t acc;

  always_comb begin
    lb1_d = lb1_q;
    lb2_d = lb2_q;
    win_d = win_q;
    // Line buffers indexed by column: slot col holds the pixel one/two rows above
    lb1_d[col] = x;
    lb2_d[col] = lb1_q[col];
    for (int unsigned i = 0; i < 3; i++) begin
      win_d[i][0] = win_q[i][1];
      win_d[i][1] = win_q[i][2];
    end
    win_d[0][2] = lb2_q[col];
    win_d[1][2] = lb1_q[col];
    win_d[2][2] = x;

    acc = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        acc = acc + sum_t'(K[i][j]) * sum_t'({1'b0, win_q[i][j]});
      end
    end
    sum_d = acc;
    y_d   = vld ? act_sat(sum_q >>> SHIFT) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb1_q <= '{default: '0};
      lb2_q <= '{default: '0};
      win_q <= '{default: '0};
      sum_q <= '0;
      y_q   <= '0;
    end else begin
      lb1_q <= lb1_d;
      lb2_q <= lb2_d;
      win_q <= win_d;
      sum_q <= sum_d;
      y_q   <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/cnn_parallel.sv
// Two-lane streaming 3x3 convolution: shared raster counters and valid pipe, two lanes.
// ReLU build option: CNN_RELU_EN (see cnn_pkg).
module cnn_parallel
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W  = 9,
  parameter int unsigned IMG_H  = 9,
  parameter int unsigned SHIFT0 = cnn_pkg::SHIFT0,
  parameter int unsigned SHIFT1 = cnn_pkg::SHIFT1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] x0,
  input  logic [DW-1:0] x1,
  output logic [DW-1:0] y0,
  output logic [DW-1:0] y1
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          v1_q, v1_d;
  logic          v2_q, v2_d;

  always_comb begin
    col_d = col_q + CW'(1);
    row_d = row_q;
    if (col_q == CW'(IMG_W - 1)) begin
      col_d = '0;
      row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
    end
    // Window ending at the accepted pixel is complete only from (2,2) of its frame
    v1_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
    v2_d = v1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
    end
  end

  cnn_conv3x3_lane #(.IMG_W(IMG_W), .K(K0), .SHIFT(SHIFT0)) u_lane0 (
    .clk   (clk),
    .rst_n (rst),
    .x     (x0),
    .col   (col_q),
    .vld   (v2_q),
    .y     (y0)
  );

  cnn_conv3x3_lane #(.IMG_W(IMG_W), .K(K1), .SHIFT(SHIFT1)) u_lane1 (
    .clk   (clk),
    .rst_n (rst),
    .x     (x1),
    .col   (col_q),
    .vld   (v2_q),
    .y     (y1)
  );

endmodule

// File: tb/tb_cnn_parallel.sv
// Scoreboard bench for cnn_parallel: golden 3x3 model per lane, two-cycle output latency.
module tb_cnn_parallel;

  localparam int W = 9;
  localparam int H = 9;
  localparam int KM [2][3][3] = '{'{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}},
                                  '{'{0, -1, 0}, '{-1, 4, -1}, '{0, -1, 0}}};
  localparam int SH [2] = '{4, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;

  cnn_if #(.DW(8)) bus ();

  cnn_parallel #(.IMG_W(W), .IMG_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .x0  (bus.x0),
    .x1  (bus.x1),
    .y0  (bus.y0),
    .y1  (bus.y1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int mcol = 0;
  int mrow = 0;
  int img [2][H][W];

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_px(input int l);
    int s;
    s = 0;
    if (mrow < 2 || mcol < 2) return 8'd0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += KM[l][i][j] * img[l][mrow - 2 + i][mcol - 2 + j];
    s = s >>> SH[l];
`ifdef CNN_RELU_EN
    if (s < 0)   s = 0;
    if (s > 255) s = 255;
`else
    if (s < -128) s = -128;
    if (s > 127)  s = 127;
`endif
    return 8'(s);
  endfunction

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic r);
    @(negedge clk);
    bus.x0 = a;
    bus.x1 = b;
    rst    = r;
    if (!r) begin
      #1;
      check_eq("y0_rst", bus.y0, 8'd0);
      check_eq("y1_rst", bus.y1, 8'd0);
      q0.delete();
      q1.delete();
      mcol = 0;
      mrow = 0;
    end else begin
      img[0][mrow][mcol] = int'(a);
      img[1][mrow][mcol] = int'(b);
      q0.push_back(model_px(0));
      q1.push_back(model_px(1));
      mcol++;
      if (mcol == W) begin
        mcol = 0;
        mrow = (mrow == H - 1) ? 0 : mrow + 1;
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      if (q0.size() >= 3) begin
        check_eq("y0", bus.y0, q0.pop_front());
        check_eq("y1", bus.y1, q1.pop_front());
      end else begin
        check_eq("y0_fill", bus.y0, 8'd0);
        check_eq("y1_fill", bus.y1, 8'd0);
      end
    end
  endtask

  initial begin
    bus.x0 = '0;
    bus.x1 = '0;
    #2 rst = 1'b0;

    // Reset held for three edges with random pixels
    for (int i = 0; i < 3; i++)
      step(8'($urandom), 8'($urandom), 1'b0);

    // Constant 16 on both lanes
    for (int i = 0; i < W * H; i++) step(8'd16, 8'd16, 1'b1);
    // Constant 255 on both lanes
    for (int i = 0; i < W * H; i++) step(8'd255, 8'd255, 1'b1);
    // Impulse 100 at (4,4) on lane 1
    for (int i = 0; i < W * H; i++)
      step(8'd0, (i == 4 * W + 4) ? 8'd100 : 8'd0, 1'b1);
    // Impulse 160 at (4,4) on lane 0
    for (int i = 0; i < W * H; i++)
      step((i == 4 * W + 4) ? 8'd160 : 8'd0, 8'd0, 1'b1);

    // Two random frames back to back, reset pulse mid-way through the second
    for (int i = 0; i < W * H; i++) step(8'($urandom), 8'($urandom), 1'b1);
    for (int i = 0; i < 40; i++)    step(8'($urandom), 8'($urandom), 1'b1);
    step(8'($urandom), 8'($urandom), 1'b0);
    for (int i = 0; i < W * H + 2; i++) step(8'($urandom), 8'($urandom), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
